// File: rtl/cache_pmu_mc.sv
// Multi-channel cache performance monitor: per-port access, miss and stall
// counters with a snapshot shadow bank and a combinational readout mux.
module cache_pmu_mc #(
    parameter int  NUM_CH   = 2,
    parameter int  CNT_W    = 32,
    parameter bit  SATURATE = 1'b1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmu_en,
    input  logic              pmu_clr,
    input  logic              pmu_snap,
    input  logic [NUM_CH-1:0] cache_ren,
    input  logic [NUM_CH-1:0] cache_wen,
    input  logic [NUM_CH-1:0] cache_stall,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] ovf
);

    typedef enum logic {IDLE, STALL} state_t;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (SATURATE && (v == '1)) return v;
        return v + 1'b1;
    endfunction

    logic [CNT_W-1:0] ch_data [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           state, state_nx;
        logic             cause, cause_nx;
        logic [CNT_W-1:0] run, run_nx;
        logic [CNT_W-1:0] live   [7];
        logic [CNT_W-1:0] shadow [7];
        logic [5:0]       inc;
        logic             ovf_q;

        // inc bits follow the counter numbering: 0 rd, 1 wr, 2/3 misses, 4/5 stall cycles
        always_comb begin
            state_nx = state;
            cause_nx = cause;
            run_nx   = run;
            inc      = '0;
            case (state)
                IDLE: begin
                    inc[0] = cache_ren[c];
                    inc[1] = cache_wen[c];
                    if (cache_stall[c] && cache_ren[c]) begin
                        inc[2]   = 1'b1;
                        inc[4]   = 1'b1;
                        cause_nx = 1'b0;
                        run_nx   = {{(CNT_W-1){1'b0}}, 1'b1};
                        state_nx = STALL;
                    end else if (cache_stall[c] && cache_wen[c]) begin
                        inc[3]   = 1'b1;
                        inc[5]   = 1'b1;
                        cause_nx = 1'b1;
                        run_nx   = {{(CNT_W-1){1'b0}}, 1'b1};
                        state_nx = STALL;
                    end
                end
                STALL: begin
                    if (cache_stall[c]) begin
                        if (cause) inc[5] = 1'b1;
                        else       inc[4] = 1'b1;
                        run_nx = bump(run);
                    end else begin
                        state_nx = IDLE;
                        cause_nx = 1'b0;
                        run_nx   = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        // Snapshot samples pre-edge values, so it composes with a same-cycle clear
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cause <= 1'b0;
                run   <= '0;
                ovf_q <= 1'b0;
                for (int k = 0; k < 7; k++) begin
                    live[k]   <= '0;
                    shadow[k] <= '0;
                end
            end else begin
                state <= state_nx;
                cause <= cause_nx;
                if (pmu_snap) begin
                    for (int k = 0; k < 7; k++) shadow[k] <= live[k];
                end
                if (pmu_clr) begin
                    run   <= '0;
                    ovf_q <= 1'b0;
                    for (int k = 0; k < 7; k++) live[k] <= '0;
                end else begin
                    run <= run_nx;
                    if (pmu_en) begin
                        for (int k = 0; k < 6; k++) begin
                            if (inc[k]) begin
                                if (live[k] == '1) ovf_q <= 1'b1;
                                live[k] <= bump(live[k]);
                            end
                        end
                        if (run_nx > live[6]) live[6] <= run_nx;
                    end
                end
            end
        end

        assign ch_data[c] = (rd_sel == 3'd7) ? '0 : shadow[rd_sel];
        assign ovf[c]     = ovf_q;
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_ch) < NUM_CH) rd_data = ch_data[rd_ch];
    end

endmodule

// File: tb/tb_cache_pmu_mc.sv
// Self-checking bench for cache_pmu_mc: directed scenarios plus randomized
// traffic against an event-count model, on a saturating and a wrapping instance.
module tb_cache_pmu_mc;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pmu_en, pmu_clr, pmu_snap;
    logic [1:0] cache_ren, cache_wen, cache_stall;
    logic [0:0] rd_ch;
    logic [2:0] rd_sel;
    logic [7:0] rd_data_sat, rd_data_wrap;
    logic [1:0] ovf_sat, ovf_wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model keeps raw (unbounded) event counts; each instance's view is derived from them
    int live_cnt   [NUM_CH][7];
    int shadow_cnt [NUM_CH][7];
    bit in_stall   [NUM_CH];
    bit st_cause   [NUM_CH];
    int run_len    [NUM_CH];

    cache_pmu_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .pmu_en(pmu_en), .pmu_clr(pmu_clr), .pmu_snap(pmu_snap),
        .cache_ren(cache_ren), .cache_wen(cache_wen), .cache_stall(cache_stall),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data_sat), .ovf(ovf_sat));

    cache_pmu_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .pmu_en(pmu_en), .pmu_clr(pmu_clr), .pmu_snap(pmu_snap),
        .cache_ren(cache_ren), .cache_wen(cache_wen), .cache_stall(cache_stall),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data_wrap), .ovf(ovf_wrap));

    always #50 clk = ~clk;

    function automatic void modelReset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            in_stall[ch] = 1'b0;
            st_cause[ch] = 1'b0;
            run_len[ch]  = 0;
            for (int k = 0; k < 7; k++) begin
                live_cnt[ch][k]   = 0;
                shadow_cnt[ch][k] = 0;
            end
        end
    endfunction

    function automatic void modelStep();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int ev [6];
            bit nstall, ncause;
            int nrun;
            for (int k = 0; k < 6; k++) ev[k] = 0;
            nstall = in_stall[ch];
            ncause = st_cause[ch];
            nrun   = run_len[ch];
            if (pmu_snap) begin
                for (int k = 0; k < 7; k++) shadow_cnt[ch][k] = live_cnt[ch][k];
            end
            if (!in_stall[ch]) begin
                ev[0] = int'(cache_ren[ch]);
                ev[1] = int'(cache_wen[ch]);
                if (cache_stall[ch] && cache_ren[ch]) begin
                    ev[2] = 1; ev[4] = 1; nstall = 1'b1; ncause = 1'b0; nrun = 1;
                end else if (cache_stall[ch] && cache_wen[ch]) begin
                    ev[3] = 1; ev[5] = 1; nstall = 1'b1; ncause = 1'b1; nrun = 1;
                end
            end else if (cache_stall[ch]) begin
                ev[st_cause[ch] ? 5 : 4] = 1;
                nrun = run_len[ch] + 1;
            end else begin
                nstall = 1'b0; ncause = 1'b0; nrun = 0;
            end
            in_stall[ch] = nstall;
            st_cause[ch] = ncause;
            if (pmu_clr) begin
                run_len[ch] = 0;
                for (int k = 0; k < 7; k++) live_cnt[ch][k] = 0;
            end else begin
                run_len[ch] = nrun;
                if (pmu_en) begin
                    for (int k = 0; k < 6; k++) live_cnt[ch][k] += ev[k];
                    if (nrun > live_cnt[ch][6]) live_cnt[ch][6] = nrun;
                end
            end
        end
    endfunction

    always @(posedge clk) if (!rst) modelStep();

    function automatic logic [7:0] expRead(input bit wrap, input int ch, input int sel);
        int raw;
        if (sel == 7 || ch >= NUM_CH) return 8'd0;
        raw = shadow_cnt[ch][sel];
        if (wrap) return 8'(raw % 256);
        return (raw > 255) ? 8'd255 : 8'(raw);
    endfunction

    function automatic logic [1:0] expOvf();
        logic [1:0] r = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int k = 0; k < 6; k++)
                if (live_cnt[ch][k] >= 256) r[ch] = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ren, input logic [1:0] wen, input logic [1:0] stall,
                                 input logic en, input logic clr, input logic snap);
        cache_ren   = ren;
        cache_wen   = wen;
        cache_stall = stall;
        pmu_en      = en;
        pmu_clr     = clr;
        pmu_snap    = snap;
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string tag, input int ch, input int sel, input int exp_sat, input int exp_wrap);
        rd_ch  = 1'(ch);
        rd_sel = 3'(sel);
        #1;
        checkOutput({tag, "_sat"},  64'(rd_data_sat),  64'(exp_sat));
        checkOutput({tag, "_wrap"}, 64'(rd_data_wrap), 64'(exp_wrap));
    endtask

    task automatic doReset();
        cache_ren = '0; cache_wen = '0; cache_stall = '0;
        pmu_en = 1'b0; pmu_clr = 1'b0; pmu_snap = 1'b0;
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rd_ch = '0; rd_sel = '0;
        cache_ren = '0; cache_wen = '0; cache_stall = '0;
        pmu_en = 1'b0; pmu_clr = 1'b0; pmu_snap = 1'b0;
        #2;
        doReset();
        checkOutput("reset_ovf_sat", 64'(ovf_sat), 64'd0);
        readCheck("reset_rd", 0, 0, 0, 0);

        // Five plain reads on ch0
        for (int i = 0; i < 5; i++) applyStimulus(2'b01, 2'b00, 2'b00, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 0, 1);
        readCheck("r5_rdcnt", 0, 0, 5, 5);
        readCheck("r5_rdmiss", 0, 2, 0, 0);
        readCheck("r5_rdstall", 0, 4, 0, 0);
        readCheck("r5_sel7", 0, 7, 0, 0);

        // Four-cycle write stall on ch1
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(2'b00, 2'b10, 2'b10, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 0, 1);
        readCheck("ws_wrcnt", 1, 1, 1, 1);
        readCheck("ws_wrmiss", 1, 3, 1, 1);
        readCheck("ws_wrstall", 1, 5, 4, 4);
        readCheck("ws_maxlen", 1, 6, 4, 4);
        readCheck("ws_rdcnt", 1, 0, 0, 0);

        // Read and write with stall together: read wins the miss
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b01, 2'b01, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 0, 1);
        readCheck("rw_rdcnt", 0, 0, 1, 1);
        readCheck("rw_wrcnt", 0, 1, 1, 1);
        readCheck("rw_rdmiss", 0, 2, 1, 1);
        readCheck("rw_wrmiss", 0, 3, 0, 0);
        readCheck("rw_rdstall", 0, 4, 3, 3);
        for (int k = 0; k < 7; k++) readCheck($sformatf("rw_ch1_%0d", k), 1, k, 0, 0);

        // 300 reads: saturate vs wrap, then clear the overflow flags
        doReset();
        for (int i = 0; i < 300; i++) applyStimulus(2'b01, 2'b00, 2'b00, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 0, 1);
        readCheck("sat_rdcnt", 0, 0, 255, 44);
        checkOutput("sat_ovf_sat", 64'(ovf_sat), 64'd1);
        checkOutput("sat_ovf_wrap", 64'(ovf_wrap), 64'd1);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 1, 0);
        checkOutput("clr_ovf_sat", 64'(ovf_sat), 64'd0);
        checkOutput("clr_ovf_wrap", 64'(ovf_wrap), 64'd0);

        // Counting disabled mid-stall
        doReset();
        applyStimulus(2'b01, 2'b00, 2'b01, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 0, 1);
        readCheck("en_rdstall", 0, 4, 1, 1);
        readCheck("en_rdmiss", 0, 2, 1, 1);
        readCheck("en_rdcnt", 0, 0, 1, 1);

        // Reset asserted in the middle of a stall
        doReset();
        applyStimulus(2'b01, 2'b00, 2'b01, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b01, 1, 0, 1);
        readCheck("prerst_rdcnt", 0, 0, 1, 1);
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst_rd_sat", 64'(rd_data_sat), 64'd0);
        checkOutput("async_rst_rd_wrap", 64'(rd_data_wrap), 64'd0);
        checkOutput("async_rst_ovf", 64'(ovf_sat), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(2'b01, 2'b00, 2'b01, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b01, 1, 0, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 1, 0, 1);
        readCheck("postrst_rdmiss", 0, 2, 1, 1);
        readCheck("postrst_rdstall", 0, 4, 2, 2);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                modelReset();
                #1;
                checkOutput("rand_rst_rd", 64'(rd_data_sat), 64'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                continue;
            end
            cache_ren   = 2'($urandom);
            cache_wen   = 2'($urandom);
            cache_stall = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            pmu_en      = ($urandom_range(0, 7) != 0);
            pmu_clr     = ($urandom_range(0, 29) == 0);
            pmu_snap    = ($urandom_range(0, 5) == 0);
            rd_ch       = 1'($urandom);
            rd_sel      = 3'($urandom);
            @(posedge clk);
            #1;
            checkOutput("rand_rd_sat", 64'(rd_data_sat), 64'(expRead(0, int'(rd_ch), int'(rd_sel))));
            checkOutput("rand_rd_wrap", 64'(rd_data_wrap), 64'(expRead(1, int'(rd_ch), int'(rd_sel))));
            checkOutput("rand_ovf_sat", 64'(ovf_sat), 64'(expOvf()));
            checkOutput("rand_ovf_wrap", 64'(ovf_wrap), 64'(expOvf()));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
